// File: rtl/csr_trap_unit.sv
// csr_trap_unit: machine-mode CSR file with trap entry, mret and fetch redirect
//   Optional 64-bit mcycle/minstret counters are built when CSR_COUNTERS_EN is defined.
//   Ports:
//     clk, rst_n                          clock, synchronous active-low reset
//     csr_raddr/csr_rdata/csr_rd_illegal  ID-stage combinational read (with write bypass)
//     csr_we/csr_waddr/csr_wop/csr_wdata  EX-stage read-modify-write
//     csr_wr_illegal                      write to unimplemented or read-only CSR
//     exc_valid/exc_cause/exc_pc/exc_tval synchronous exception at commit
//     irq_sw/irq_timer/irq_ext            level interrupt sources
//     irq_pending, irq_take, irq_pc       interrupt request / acceptance
//     mret, instr_retire                  mret commit, retire strobe
//     trap_redirect/trap_target           registered redirect pulse and PC
module csr_trap_unit #(
   parameter int XLEN = 32,
   parameter logic [XLEN-1:0] HART_ID = '0,
   parameter logic [XLEN-1:0] MTVEC_RESET = '0
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [11:0]     csr_raddr,
   output logic [XLEN-1:0] csr_rdata,
   output logic            csr_rd_illegal,
   input  logic            csr_we,
   input  logic [11:0]     csr_waddr,
   input  logic [1:0]      csr_wop,
   input  logic [XLEN-1:0] csr_wdata,
   output logic            csr_wr_illegal,
   input  logic            exc_valid,
   input  logic [3:0]      exc_cause,
   input  logic [XLEN-1:0] exc_pc,
   input  logic [XLEN-1:0] exc_tval,
   input  logic            irq_sw,
   input  logic            irq_timer,
   input  logic            irq_ext,
   output logic            irq_pending,
   input  logic            irq_take,
   input  logic [XLEN-1:0] irq_pc,
   input  logic            mret,
   input  logic            instr_retire,
   output logic            trap_redirect,
   output logic [XLEN-1:0] trap_target
);
   logic            st_mie, st_mpie;
   logic [XLEN-1:0] mie_r, mtvec_r, mepc_r, mcause_r, mtval_r, mip_r;
   logic [XLEN-1:0] mstatus_v, old_w, op_v, new_v, rd_v, base, pend;
   logic            rd_ill_w, byp, take_irq, take_mret, do_wr;
   logic [3:0]      code;
`ifdef CSR_COUNTERS_EN
   logic [63:0]     mcycle_r, minstret_r;
`endif

   function automatic logic [XLEN:0] rd_csr(input logic [11:0] a);
      logic [XLEN-1:0] v;
      logic            ill;
      v = '0;
      ill = 1'b0;
      case (a)
         12'h300: v = mstatus_v;
         12'h304: v = mie_r;
         12'h305: v = mtvec_r;
         12'h341: v = mepc_r;
         12'h342: v = mcause_r;
         12'h343: v = mtval_r;
         12'h344: v = mip_r;
         12'hF14: v = HART_ID;
`ifdef CSR_COUNTERS_EN
         12'hB00: v = mcycle_r[XLEN-1:0];
         12'hB02: v = minstret_r[XLEN-1:0];
         12'hB80: if (XLEN == 32) v = XLEN'(mcycle_r[63:32]); else ill = 1'b1;
         12'hB82: if (XLEN == 32) v = XLEN'(minstret_r[63:32]); else ill = 1'b1;
`endif
         default: ill = 1'b1;
      endcase
      return {ill, v};
   endfunction

   // WARL legalisation, expressed in the form the CSR reads back as
   function automatic logic [XLEN-1:0] legal(input logic [11:0] a, input logic [XLEN-1:0] v);
      return a == 12'h300 ? (v & XLEN'('h88)) | XLEN'('h1800) :
             a == 12'h304 ? v & XLEN'('h888) :
             a == 12'h305 ? v & ~XLEN'(2) :
             a == 12'h341 ? v & ~XLEN'(3) : v;
   endfunction

`ifdef CSR_COUNTERS_EN
   // An explicit write of either half replaces it and suppresses the increment
   function automatic logic [63:0] cnt_nxt(input logic [63:0] cur, input logic inc,
                                           input logic lo, input logic hi);
      return lo ? (XLEN == 32 ? {cur[63:32], new_v[31:0]} : 64'(new_v)) :
             hi ? {new_v[31:0], cur[31:0]} : cur + 64'(inc);
   endfunction
`endif

   always_comb begin
      mstatus_v = XLEN'({2'b11, 3'b0, st_mpie, 3'b0, st_mie, 3'b0});
      {rd_ill_w, old_w} = rd_csr(csr_waddr);
      {csr_rd_illegal, rd_v} = rd_csr(csr_raddr);
      csr_wr_illegal = csr_we & (rd_ill_w | csr_waddr == 12'hF14 | csr_waddr == 12'h344);
      op_v = csr_wop == 2'b00 ? csr_wdata :
             csr_wop == 2'b01 ? old_w | csr_wdata :
             csr_wop == 2'b10 ? old_w & ~csr_wdata : old_w;
      new_v = legal(csr_waddr, op_v);
      byp = csr_we & ~csr_wr_illegal & (csr_waddr == csr_raddr);
      csr_rdata = byp ? new_v : rd_v;
      pend = mie_r & mip_r;
      irq_pending = st_mie & |pend;
      code = pend[11] ? 4'd11 : pend[3] ? 4'd3 : 4'd7;
      base = {mtvec_r[XLEN-1:2], 2'b00};
      take_irq = ~exc_valid & irq_take & irq_pending;
      take_mret = ~exc_valid & ~take_irq & mret;
      do_wr = ~exc_valid & ~take_irq & ~take_mret & csr_we & ~csr_wr_illegal & csr_wop != 2'b11;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         st_mie <= 1'b0;
         st_mpie <= 1'b0;
         mie_r <= '0;
         mtvec_r <= MTVEC_RESET & ~XLEN'(2);
         mepc_r <= '0;
         mcause_r <= '0;
         mtval_r <= '0;
         mip_r <= '0;
         trap_redirect <= 1'b0;
         trap_target <= '0;
      end else begin
         mip_r <= XLEN'({irq_ext, 3'b0, irq_timer, 3'b0, irq_sw, 3'b0});
         trap_redirect <= exc_valid | take_irq | take_mret;
         if (exc_valid) begin
            mepc_r <= exc_pc & ~XLEN'(3);
            mcause_r <= XLEN'(exc_cause);
            mtval_r <= exc_tval;
            st_mpie <= st_mie;
            st_mie <= 1'b0;
            trap_target <= base;
         end else if (take_irq) begin
            mepc_r <= irq_pc & ~XLEN'(3);
            mcause_r <= {1'b1, {(XLEN-5){1'b0}}, code};
            mtval_r <= '0;
            st_mpie <= st_mie;
            st_mie <= 1'b0;
            trap_target <= mtvec_r[0] ? base + XLEN'({code, 2'b00}) : base;
         end else if (take_mret) begin
            st_mie <= st_mpie;
            st_mpie <= 1'b1;
            trap_target <= mepc_r;
         end else if (do_wr) begin
            case (csr_waddr)
               12'h300: {st_mpie, st_mie} <= {new_v[7], new_v[3]};
               12'h304: mie_r <= new_v;
               12'h305: mtvec_r <= new_v;
               12'h341: mepc_r <= new_v;
               12'h342: mcause_r <= new_v;
               12'h343: mtval_r <= new_v;
               default: ;
            endcase
         end
      end
   end

`ifdef CSR_COUNTERS_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mcycle_r <= '0;
         minstret_r <= '0;
      end else begin
         mcycle_r <= cnt_nxt(mcycle_r, 1'b1, do_wr & csr_waddr == 12'hB00, do_wr & csr_waddr == 12'hB80);
         minstret_r <= cnt_nxt(minstret_r, instr_retire, do_wr & csr_waddr == 12'hB02,
                               do_wr & csr_waddr == 12'hB82);
      end
   end
`endif
endmodule

// File: tb/tb_csr_trap_unit.sv
// tb_csr_trap_unit: directed self-checking bench for csr_trap_unit
module tb_csr_trap_unit;
   localparam logic [31:0] HART = 32'h5;
   localparam logic [31:0] MTR = 32'h200;
   logic clk = 1'b0, rst_n = 1'b0;
   logic [11:0] csr_raddr = '0, csr_waddr = '0;
   logic [31:0] csr_rdata, csr_wdata = '0, exc_pc = '0, exc_tval = '0, irq_pc = '0, trap_target;
   logic [1:0] csr_wop = '0;
   logic [3:0] exc_cause = '0;
   logic csr_rd_illegal, csr_wr_illegal, irq_pending, trap_redirect;
   logic csr_we = 0, exc_valid = 0, irq_sw = 0, irq_timer = 0, irq_ext = 0, irq_take = 0;
   logic mret = 0, instr_retire = 0;
   logic [31:0] v;
   int checks = 0, failures = 0;

   csr_trap_unit #(.XLEN(32), .HART_ID(HART), .MTVEC_RESET(MTR)) dut (
      .clk(clk), .rst_n(rst_n), .csr_raddr(csr_raddr), .csr_rdata(csr_rdata),
      .csr_rd_illegal(csr_rd_illegal), .csr_we(csr_we), .csr_waddr(csr_waddr), .csr_wop(csr_wop),
      .csr_wdata(csr_wdata), .csr_wr_illegal(csr_wr_illegal), .exc_valid(exc_valid),
      .exc_cause(exc_cause), .exc_pc(exc_pc), .exc_tval(exc_tval), .irq_sw(irq_sw),
      .irq_timer(irq_timer), .irq_ext(irq_ext), .irq_pending(irq_pending), .irq_take(irq_take),
      .irq_pc(irq_pc), .mret(mret), .instr_retire(instr_retire), .trap_redirect(trap_redirect),
      .trap_target(trap_target));

   always #50 clk = ~clk;

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic rd(input logic [11:0] a);
      csr_raddr = a;
      #1;
      v = csr_rdata;
   endtask

   task automatic wr(input logic [11:0] a, input logic [1:0] op, input logic [31:0] d);
      csr_we = 1;
      csr_waddr = a;
      csr_wop = op;
      csr_wdata = d;
      step;
      csr_we = 0;
   endtask

   task automatic test_reset;
      rst_n = 0;
      exc_valid = 1;
      step;
      step;
      exc_valid = 0;
      checks++; if (trap_redirect !== 1'b0) begin failures++; $display("FAIL rst_redirect got=%b exp=0", trap_redirect); end
      rst_n = 1;
      checks++; if (trap_target !== 32'h0) begin failures++; $display("FAIL rst_target got=%h exp=0", trap_target); end
      checks++; if (irq_pending !== 1'b0) begin failures++; $display("FAIL rst_pending got=%b exp=0", irq_pending); end
      rd(12'h300);
      checks++; if (v !== 32'h1800) begin failures++; $display("FAIL rst_mstatus got=%h exp=1800", v); end
      checks++; if (csr_rd_illegal !== 1'b0) begin failures++; $display("FAIL rst_mstatus_ill got=%b exp=0", csr_rd_illegal); end
      rd(12'h305);
      checks++; if (v !== MTR) begin failures++; $display("FAIL rst_mtvec got=%h exp=%h", v, MTR); end
      rd(12'hF14);
      checks++; if (v !== HART) begin failures++; $display("FAIL rst_hartid got=%h exp=%h", v, HART); end
      rd(12'h341);
      checks++; if (v !== 32'h0) begin failures++; $display("FAIL rst_mepc got=%h exp=0", v); end
      rd(12'h7C0);
      checks++; if (v !== 32'h0) begin failures++; $display("FAIL unimpl_rdata got=%h exp=0", v); end
      checks++; if (csr_rd_illegal !== 1'b1) begin failures++; $display("FAIL unimpl_ill got=%b exp=1", csr_rd_illegal); end
   endtask

   task automatic test_rmw;
      csr_we = 1; csr_waddr = 12'h304; csr_wop = 2'b00; csr_wdata = 32'hFFFF_FFFF;
      rd(12'h304);
      checks++; if (v !== 32'h888) begin failures++; $display("FAIL bypass_mie got=%h exp=888", v); end
      step;
      csr_we = 0;
      rd(12'h304);
      checks++; if (v !== 32'h888) begin failures++; $display("FAIL mie_write got=%h exp=888", v); end
      wr(12'h300, 2'b01, 32'h8);
      rd(12'h300);
      checks++; if (v !== 32'h1808) begin failures++; $display("FAIL mstatus_set got=%h exp=1808", v); end
      wr(12'h304, 2'b10, 32'h8);
      rd(12'h304);
      checks++; if (v !== 32'h880) begin failures++; $display("FAIL mie_clear got=%h exp=880", v); end
      wr(12'h304, 2'b11, 32'hFFFF_FFFF);
      rd(12'h304);
      checks++; if (v !== 32'h880) begin failures++; $display("FAIL wop_noop got=%h exp=880", v); end
      wr(12'h341, 2'b00, 32'h123);
      rd(12'h341);
      checks++; if (v !== 32'h120) begin failures++; $display("FAIL mepc_mask got=%h exp=120", v); end
      wr(12'h305, 2'b00, 32'h3);
      rd(12'h305);
      checks++; if (v !== 32'h1) begin failures++; $display("FAIL mtvec_mask got=%h exp=1", v); end
      wr(12'h342, 2'b00, 32'hFFFF_FFFF);
      rd(12'h342);
      checks++; if (v !== 32'hFFFF_FFFF) begin failures++; $display("FAIL mcause_write got=%h exp=ffffffff", v); end
   endtask

   task automatic test_illegal;
      csr_we = 1; csr_waddr = 12'hF14; csr_wop = 2'b00; csr_wdata = 32'h0;
      #1;
      checks++; if (csr_wr_illegal !== 1'b1) begin failures++; $display("FAIL wr_ill_hartid got=%b exp=1", csr_wr_illegal); end
      step;
      csr_waddr = 12'h344; csr_wdata = 32'hFFFF_FFFF;
      #1;
      checks++; if (csr_wr_illegal !== 1'b1) begin failures++; $display("FAIL wr_ill_mip got=%b exp=1", csr_wr_illegal); end
      step;
      csr_waddr = 12'h300;
      csr_wop = 2'b11;
      #1;
      checks++; if (csr_wr_illegal !== 1'b0) begin failures++; $display("FAIL wr_legal_mstatus got=%b exp=0", csr_wr_illegal); end
      csr_we = 0;
      rd(12'hF14);
      checks++; if (v !== HART) begin failures++; $display("FAIL hartid_kept got=%h exp=%h", v, HART); end
      rd(12'h344);
      checks++; if (v !== 32'h0) begin failures++; $display("FAIL mip_kept got=%h exp=0", v); end
   endtask

   task automatic test_irq;
      wr(12'h305, 2'b00, 32'h101);
      wr(12'h304, 2'b00, 32'h888);
      irq_ext = 1; irq_sw = 1; irq_timer = 1;
      #1;
      checks++; if (irq_pending !== 1'b0) begin failures++; $display("FAIL pend_early got=%b exp=0", irq_pending); end
      step;
      checks++; if (irq_pending !== 1'b1) begin failures++; $display("FAIL pend_set got=%b exp=1", irq_pending); end
      rd(12'h344);
      checks++; if (v !== 32'h888) begin failures++; $display("FAIL mip_read got=%h exp=888", v); end
      irq_take = 1; irq_pc = 32'h40;
      step;
      irq_take = 0;
      checks++; if (trap_redirect !== 1'b1) begin failures++; $display("FAIL irq_redirect got=%b exp=1", trap_redirect); end
      checks++; if (trap_target !== 32'h12C) begin failures++; $display("FAIL irq_target got=%h exp=12c", trap_target); end
      checks++; if (irq_pending !== 1'b0) begin failures++; $display("FAIL irq_pend_masked got=%b exp=0", irq_pending); end
      rd(12'h341);
      checks++; if (v !== 32'h40) begin failures++; $display("FAIL irq_mepc got=%h exp=40", v); end
      rd(12'h342);
      checks++; if (v !== 32'h8000_000B) begin failures++; $display("FAIL irq_mcause got=%h exp=8000000b", v); end
      rd(12'h300);
      checks++; if (v !== 32'h1880) begin failures++; $display("FAIL irq_mstatus got=%h exp=1880", v); end
      rd(12'h343);
      checks++; if (v !== 32'h0) begin failures++; $display("FAIL irq_mtval got=%h exp=0", v); end
      irq_ext = 0;
      step;
      checks++; if (trap_redirect !== 1'b0) begin failures++; $display("FAIL redirect_pulse got=%b exp=0", trap_redirect); end
      mret = 1;
      step;
      mret = 0;
      checks++; if (trap_target !== 32'h40 || trap_redirect !== 1'b1) begin failures++; $display("FAIL mret_target got=%h/%b exp=40/1", trap_target, trap_redirect); end
      rd(12'h300);
      checks++; if (v !== 32'h1888) begin failures++; $display("FAIL mret_mstatus got=%h exp=1888", v); end
      irq_take = 1; irq_pc = 32'h44;
      step;
      irq_take = 0;
      checks++; if (trap_target !== 32'h10C) begin failures++; $display("FAIL sw_prio_target got=%h exp=10c", trap_target); end
      rd(12'h342);
      checks++; if (v !== 32'h8000_0003) begin failures++; $display("FAIL sw_prio_mcause got=%h exp=80000003", v); end
      mret = 1;
      irq_sw = 0; irq_timer = 0;
      step;
      mret = 0;
      checks++; if (trap_target !== 32'h44) begin failures++; $display("FAIL mret2_target got=%h exp=44", trap_target); end
      step;
      irq_take = 1; irq_pc = 32'h80;
      step;
      irq_take = 0;
      checks++; if (trap_redirect !== 1'b0) begin failures++; $display("FAIL take_nopend got=%b exp=0", trap_redirect); end
      rd(12'h341);
      checks++; if (v !== 32'h44) begin failures++; $display("FAIL take_nopend_mepc got=%h exp=44", v); end
   endtask

   task automatic test_priority;
      exc_valid = 1; exc_cause = 4'd2; exc_pc = 32'h80; exc_tval = 32'hDEAD;
      mret = 1; irq_take = 1;
      csr_we = 1; csr_waddr = 12'h342; csr_wop = 2'b00; csr_wdata = 32'h55;
      step;
      exc_valid = 0; mret = 0; irq_take = 0; csr_we = 0;
      checks++; if (trap_redirect !== 1'b1 || trap_target !== 32'h100) begin failures++; $display("FAIL exc_target got=%h/%b exp=100/1", trap_target, trap_redirect); end
      rd(12'h341);
      checks++; if (v !== 32'h80) begin failures++; $display("FAIL exc_mepc got=%h exp=80", v); end
      rd(12'h342);
      checks++; if (v !== 32'h2) begin failures++; $display("FAIL exc_mcause got=%h exp=2", v); end
      rd(12'h343);
      checks++; if (v !== 32'hDEAD) begin failures++; $display("FAIL exc_mtval got=%h exp=dead", v); end
      rd(12'h300);
      checks++; if (v !== 32'h1880) begin failures++; $display("FAIL exc_mstatus got=%h exp=1880", v); end
      mret = 1;
      csr_we = 1; csr_waddr = 12'h343; csr_wdata = 32'h77;
      step;
      mret = 0; csr_we = 0;
      checks++; if (trap_target !== 32'h80) begin failures++; $display("FAIL mret3_target got=%h exp=80", trap_target); end
      rd(12'h300);
      checks++; if (v !== 32'h1888) begin failures++; $display("FAIL mret3_mstatus got=%h exp=1888", v); end
      rd(12'h343);
      checks++; if (v !== 32'hDEAD) begin failures++; $display("FAIL dropped_write got=%h exp=dead", v); end
   endtask

   task automatic test_counters;
`ifdef CSR_COUNTERS_EN
      wr(12'hB80, 2'b00, 32'hFFFF_FFFF);
      wr(12'hB00, 2'b00, 32'hFFFF_FFFF);
      rd(12'hB00);
      checks++; if (v !== 32'hFFFF_FFFF) begin failures++; $display("FAIL mcycle_lo got=%h exp=ffffffff", v); end
      rd(12'hB80);
      checks++; if (v !== 32'hFFFF_FFFF) begin failures++; $display("FAIL mcycle_hi got=%h exp=ffffffff", v); end
      step;
      rd(12'hB00);
      checks++; if (v !== 32'h0) begin failures++; $display("FAIL wrap_lo got=%h exp=0", v); end
      rd(12'hB80);
      checks++; if (v !== 32'h0) begin failures++; $display("FAIL wrap_hi got=%h exp=0", v); end
      instr_retire = 1;
      wr(12'hB02, 2'b00, 32'h1234);
      instr_retire = 0;
      rd(12'hB02);
      checks++; if (v !== 32'h1234) begin failures++; $display("FAIL minstret_wr got=%h exp=1234", v); end
      instr_retire = 1;
      step;
      instr_retire = 0;
      rd(12'hB02);
      checks++; if (v !== 32'h1235) begin failures++; $display("FAIL minstret_inc got=%h exp=1235", v); end
`else
      rd(12'hB00);
      checks++; if (csr_rd_illegal !== 1'b1 || v !== 32'h0) begin failures++; $display("FAIL no_mcycle got=%h/%b exp=0/1", v, csr_rd_illegal); end
      csr_we = 1; csr_waddr = 12'hB02; csr_wop = 2'b00; csr_wdata = 32'h1;
      #1;
      checks++; if (csr_wr_illegal !== 1'b1) begin failures++; $display("FAIL no_minstret_wr got=%b exp=1", csr_wr_illegal); end
      step;
      csr_we = 0;
`endif
   endtask

   task automatic test_reset_midflight;
      exc_valid = 1; exc_pc = 32'h90;
      step;
      exc_valid = 0;
      rst_n = 0;
      step;
      rst_n = 1;
      checks++; if (trap_redirect !== 1'b0 || trap_target !== 32'h0) begin failures++; $display("FAIL rst_midflight got=%h/%b exp=0/0", trap_target, trap_redirect); end
      rd(12'h341);
      checks++; if (v !== 32'h0) begin failures++; $display("FAIL rst_mepc_clr got=%h exp=0", v); end
   endtask

   initial begin
      test_reset;
      test_rmw;
      test_illegal;
      test_irq;
      test_priority;
      test_counters;
      test_reset_midflight;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
